// File: rtl/datapath_gen2_if.sv
// Control/bus bundle for datapath_gen2: the controller (master) drives enables
// and memory responses; the datapath (slave) returns registers and status.
interface datapath_gen2_if #(
  parameter int WIDTH  = 32,
  parameter int RSEL_W = 4
);
  logic              reg_in_en;
  logic              reg_out_en;
  logic [RSEL_W-1:0] reg_in_sel;
  logic [RSEL_W-1:0] reg_out_sel;
  logic              pc_out;
  logic              mdr_out;
  logic              zlo_out;
  logic              zhi_out;
  logic              pc_in;
  logic              ir_in;
  logic              y_in;
  logic              mar_in;
  logic              mdr_in;
  logic              z_in;
  logic              inc_pc;
  logic [3:0]        alu_op;
  logic              alu_start;
  logic              mem_read;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_req;
  logic [WIDTH-1:0]  mar;
  logic [WIDTH-1:0]  ir;
  logic [WIDTH-1:0]  bus;
  logic              busy;
  logic              done;
  logic              bus_conflict;
  logic              err_sticky;

  modport master (
    output reg_in_en, reg_out_en, reg_in_sel, reg_out_sel,
           pc_out, mdr_out, zlo_out, zhi_out,
           pc_in, ir_in, y_in, mar_in, mdr_in, z_in,
           inc_pc, alu_op, alu_start, mem_read, mem_ack, mem_rdata,
    input  mem_req, mar, ir, bus, busy, done, bus_conflict, err_sticky
  );

  modport slave (
    input  reg_in_en, reg_out_en, reg_in_sel, reg_out_sel,
           pc_out, mdr_out, zlo_out, zhi_out,
           pc_in, ir_in, y_in, mar_in, mdr_in, z_in,
           inc_pc, alu_op, alu_start, mem_read, mem_ack, mem_rdata,
    output mem_req, mar, ir, bus, busy, done, bus_conflict, err_sticky
  );
endinterface

// File: rtl/datapath_gen2.sv
// Single-bus datapath: GPR file, PC/IR/Y/Z/MAR/MDR, single-cycle ALU,
// shift-add multiplier taking WIDTH cycles, and a two-state memory read FSM.
module datapath_gen2 #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int RSEL_W = $clog2(NREGS)
) (
  input logic            clk,
  input logic            reset,
  datapath_gen2_if.slave dp
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

  logic [WIDTH-1:0]   gpr [NREGS];
  logic [WIDTH-1:0]   pc, ir_q, y, mar_q, mdr;
  logic [2*WIDTH-1:0] z;
  logic               busy_q, done_q, mem_req_q, err_q;
  mem_state_t         mem_state;

  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_next;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CNT_W-1:0]   mul_cnt;

  logic [2:0]         src_cnt;
  logic               conflict;
  logic [WIDTH-1:0]   bus_val, alu_res;
  logic [SH_W-1:0]    sh;

  // A bus with zero or several drivers reads as zero rather than an OR of sources.
  always_comb begin
    src_cnt = 3'(dp.reg_out_en) + 3'(dp.pc_out) + 3'(dp.mdr_out)
            + 3'(dp.zlo_out) + 3'(dp.zhi_out);
    conflict = (src_cnt > 3'd1);
    bus_val  = '0;
    if (src_cnt == 3'd1) begin
      if (dp.reg_out_en)   bus_val = gpr[dp.reg_out_sel];
      else if (dp.pc_out)  bus_val = pc;
      else if (dp.mdr_out) bus_val = mdr;
      else if (dp.zlo_out) bus_val = z[WIDTH-1:0];
      else                 bus_val = z[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    sh      = bus_val[SH_W-1:0];
    alu_res = '0;
    if (dp.inc_pc) begin
      alu_res = bus_val + WIDTH'(4);
    end else begin
      case (dp.alu_op)
        4'd0:    alu_res = y + bus_val;
        4'd1:    alu_res = y - bus_val;
        4'd2:    alu_res = y & bus_val;
        4'd3:    alu_res = y | bus_val;
        4'd4:    alu_res = y ^ bus_val;
        4'd5:    alu_res = ~bus_val;
        4'd6:    alu_res = -bus_val;
        4'd7:    alu_res = y << sh;
        4'd8:    alu_res = y >> sh;
        4'd9:    alu_res = $signed(y) >>> sh;
        4'd10:   alu_res = (y << sh) | (y >> (WIDTH - int'(sh)));
        4'd11:   alu_res = (y >> sh) | (y << (WIDTH - int'(sh)));
        default: alu_res = '0;
      endcase
    end
  end

  assign mul_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      pc         <= '0;
      ir_q       <= '0;
      y          <= '0;
      mar_q      <= '0;
      z          <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      if (conflict)     err_q <= 1'b1;
      if (dp.reg_in_en) gpr[dp.reg_in_sel] <= bus_val;
      if (dp.pc_in)     pc    <= bus_val;
      if (dp.ir_in)     ir_q  <= bus_val;
      if (dp.y_in)      y     <= bus_val;
      if (dp.mar_in)    mar_q <= bus_val;
      // One multiplier bit per busy cycle; the last step writes Z directly.
      if (busy_q) begin
        mul_acc    <= mul_next;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + 1'b1;
        if (mul_cnt == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          z      <= mul_next;
        end
      end else begin
        if (dp.z_in) z <= {{WIDTH{1'b0}}, alu_res};
        if (dp.alu_start) begin
          busy_q     <= 1'b1;
          mul_acc    <= '0;
          mul_mcand  <= {{WIDTH{1'b0}}, y};
          mul_mplier <= bus_val;
          mul_cnt    <= '0;
        end
      end
    end
  end

  // MDR is owned by the memory FSM: bus loads only happen while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_state <= MEM_IDLE;
      mem_req_q <= 1'b0;
      mdr       <= '0;
    end else begin
      case (mem_state)
        MEM_IDLE: begin
          if (dp.mdr_in) mdr <= bus_val;
          if (dp.mem_read) begin
            mem_state <= MEM_WAIT;
            mem_req_q <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dp.mem_ack) begin
            mdr       <= dp.mem_rdata;
            mem_state <= MEM_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          mem_state <= MEM_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dp.bus          = bus_val;
  assign dp.bus_conflict = conflict;
  assign dp.err_sticky   = err_q;
  assign dp.mar          = mar_q;
  assign dp.ir           = ir_q;
  assign dp.busy         = busy_q;
  assign dp.done         = done_q;
  assign dp.mem_req      = mem_req_q;
endmodule

// File: tb/tb_datapath_gen2.sv
// Directed bench for datapath_gen2: a 32-bit/16-reg instance for the main
// scenarios and an 8-bit/4-reg instance for the parameter sweep.
module tb_datapath_gen2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_s = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  datapath_gen2_if #(.WIDTH(32), .RSEL_W(4)) m ();
  datapath_gen2_if #(.WIDTH(8),  .RSEL_W(2)) s ();

  datapath_gen2 #(.WIDTH(32), .NREGS(16)) dut   (.clk(clk), .reset(reset),   .dp(m.slave));
  datapath_gen2 #(.WIDTH(8),  .NREGS(4))  dut_s (.clk(clk), .reset(reset_s), .dp(s.slave));

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_m();
    m.reg_in_en = 0; m.reg_out_en = 0; m.reg_in_sel = '0; m.reg_out_sel = '0;
    m.pc_out = 0; m.mdr_out = 0; m.zlo_out = 0; m.zhi_out = 0;
    m.pc_in = 0; m.ir_in = 0; m.y_in = 0; m.mar_in = 0; m.mdr_in = 0; m.z_in = 0;
    m.inc_pc = 0; m.alu_op = '0; m.alu_start = 0;
    m.mem_read = 0; m.mem_ack = 0; m.mem_rdata = '0;
  endtask

  task automatic clear_s();
    s.reg_in_en = 0; s.reg_out_en = 0; s.reg_in_sel = '0; s.reg_out_sel = '0;
    s.pc_out = 0; s.mdr_out = 0; s.zlo_out = 0; s.zhi_out = 0;
    s.pc_in = 0; s.ir_in = 0; s.y_in = 0; s.mar_in = 0; s.mdr_in = 0; s.z_in = 0;
    s.inc_pc = 0; s.alu_op = '0; s.alu_start = 0;
    s.mem_read = 0; s.mem_ack = 0; s.mem_rdata = '0;
  endtask

  // External data only enters through a memory read into MDR.
  task automatic mem_load(input logic [31:0] v);
    m.mem_read = 1; tick(); m.mem_read = 0;
    m.mem_ack = 1; m.mem_rdata = v; tick(); m.mem_ack = 0;
  endtask

  task automatic mem_load_s(input logic [7:0] v);
    s.mem_read = 1; tick(); s.mem_read = 0;
    s.mem_ack = 1; s.mem_rdata = v; tick(); s.mem_ack = 0;
  endtask

  task automatic mdr_to_y();
    m.mdr_out = 1; m.y_in = 1; tick(); clear_m();
  endtask

  // ALU op with Y as A and MDR as B, read back through zlo_out.
  task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] exp);
    m.mdr_out = 1; m.alu_op = op; m.z_in = 1; tick(); clear_m();
    m.zlo_out = 1; #1 checkOutput(tag, m.bus, exp); clear_m();
  endtask

  logic [3:0]  ops   [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                              4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
  logic [31:0] exp_b1[14] = '{32'h80000002, 32'h80000000, 32'h00000001, 32'h80000001,
                              32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000002,
                              32'h40000000, 32'hC0000000, 32'h00000003, 32'hC0000000,
                              32'h0, 32'h0};
  logic [3:0]  ops4  [4]  = '{4'd7, 4'd9, 4'd10, 4'd11};
  logic [31:0] exp_b4[4]  = '{32'h00000010, 32'hF8000000, 32'h00000018, 32'h18000000};

  initial begin
    int busy_cycles;
    int done_seen;
    clear_m();
    clear_s();
    tick(); tick();
    reset = 0;

    checkOutput("rst busy",    m.busy, 0);
    checkOutput("rst done",    m.done, 0);
    checkOutput("rst mem_req", m.mem_req, 0);
    checkOutput("rst err",     m.err_sticky, 0);
    checkOutput("rst mar",     m.mar, 0);
    checkOutput("rst ir",      m.ir, 0);
    m.pc_out = 1; #1 checkOutput("rst pc", m.bus, 0); clear_m();

    // ADD / SUB with Y=5 and GPR3=7
    mem_load(32'd5); mdr_to_y();
    mem_load(32'd7);
    m.mdr_out = 1; m.reg_in_en = 1; m.reg_in_sel = 4'd3; tick(); clear_m();
    m.reg_out_en = 1; m.reg_out_sel = 4'd3; m.alu_op = 4'd0; m.z_in = 1;
    #1 checkOutput("gpr3 on bus", m.bus, 32'd7);
    tick(); clear_m();
    m.zlo_out = 1; m.mar_in = 1; m.ir_in = 1;
    #1 checkOutput("add zlo", m.bus, 32'd12);
    tick(); clear_m();
    checkOutput("mar load", m.mar, 32'd12);
    checkOutput("ir load",  m.ir,  32'd12);
    m.zhi_out = 1; #1 checkOutput("add zhi", m.bus, 0); clear_m();
    m.reg_out_en = 1; m.reg_out_sel = 4'd3; m.alu_op = 4'd1; m.z_in = 1; tick(); clear_m();
    m.zlo_out = 1; #1 checkOutput("sub zlo", m.bus, 32'hFFFFFFFE); clear_m();
    m.zhi_out = 1; #1 checkOutput("sub zhi", m.bus, 0); clear_m();

    // Full ALU table with Y=0x80000001, B=1 then B=4
    mem_load(32'h80000001); mdr_to_y();
    mem_load(32'd1);
    for (int i = 0; i < 14; i++) alu_check($sformatf("alu op%0d b1", ops[i]), ops[i], exp_b1[i]);
    mem_load(32'd4);
    for (int i = 0; i < 4; i++) alu_check($sformatf("alu op%0d b4", ops4[i]), ops4[i], exp_b4[i]);

    // inc_pc overrides alu_op
    mem_load(32'hFFFFFFFC);
    m.mdr_out = 1; m.inc_pc = 1; m.alu_op = 4'd2; m.z_in = 1; tick(); clear_m();
    m.zlo_out = 1; #1 checkOutput("inc wrap", m.bus, 0); clear_m();
    mem_load(32'd4);
    m.mdr_out = 1; m.inc_pc = 1; m.alu_op = 4'd3; m.z_in = 1; tick(); clear_m();
    m.zlo_out = 1; m.pc_in = 1; tick(); clear_m();
    m.pc_out = 1; #1 checkOutput("pc after inc", m.bus, 32'd8); clear_m();

    // Bus conflict
    m.pc_out = 1; m.mdr_out = 1;
    #1 checkOutput("conflict bus", m.bus, 0);
    checkOutput("conflict flag", m.bus_conflict, 1);
    tick(); clear_m();
    #1 checkOutput("conflict clears", m.bus_conflict, 0);
    tick(); tick();
    checkOutput("err sticky", m.err_sticky, 1);

    // Memory: early ack ignored, then a 3-cycle wait
    m.mem_ack = 1; m.mem_rdata = 32'h12345678; tick(); clear_m();
    checkOutput("early ack req", m.mem_req, 0);
    m.mdr_out = 1; #1 checkOutput("early ack mdr", m.bus, 32'd4); clear_m();
    m.mem_read = 1; m.pc_out = 1; m.mdr_in = 1; tick(); clear_m();
    checkOutput("mem_req c1", m.mem_req, 1);
    m.mdr_out = 1; #1 checkOutput("mdr from bus", m.bus, 32'd8); clear_m();
    m.zhi_out = 1; m.mdr_in = 1; m.mem_read = 1; tick(); clear_m();
    checkOutput("mem_req c2", m.mem_req, 1);
    tick();
    checkOutput("mem_req c3", m.mem_req, 1);
    m.mdr_out = 1; #1 checkOutput("mdr_in ignored in wait", m.bus, 32'd8); clear_m();
    m.mem_ack = 1; m.mem_rdata = 32'hDEADBEEF; tick(); clear_m();
    checkOutput("mem_req drop", m.mem_req, 0);
    m.mdr_out = 1; #1 checkOutput("mdr rdata", m.bus, 32'hDEADBEEF); clear_m();

    // MUL 0xFFFFFFFF * 2
    mem_load(32'hFFFFFFFF); mdr_to_y();
    mem_load(32'd2);
    m.mdr_out = 1; m.alu_start = 1; m.alu_op = 4'd3; tick(); clear_m();
    busy_cycles = 0; done_seen = 0;
    for (int i = 0; i < 100 && m.busy; i++) begin
      busy_cycles++;
      if (m.done) done_seen++;
      if (i == 5) begin m.mdr_out = 1; m.alu_start = 1; m.z_in = 1; m.mar_in = 1; end
      tick(); clear_m();
    end
    checkOutput("mul busy cycles", busy_cycles, 32);
    checkOutput("mul no early done", done_seen, 0);
    checkOutput("mul done", m.done, 1);
    checkOutput("mar during mul", m.mar, 32'd2);
    tick();
    checkOutput("done one cycle", m.done, 0);
    checkOutput("no relaunch", m.busy, 0);
    m.zlo_out = 1; #1 checkOutput("mul zlo", m.bus, 32'hFFFFFFFE); clear_m();
    m.zhi_out = 1; #1 checkOutput("mul zhi", m.bus, 32'h1); clear_m();

    // Reset while multiplying and waiting on memory
    m.mdr_out = 1; m.ir_in = 1; m.mem_read = 1; tick(); clear_m();
    m.mdr_out = 1; m.alu_start = 1; tick(); clear_m();
    tick(); tick(); tick();
    checkOutput("pre-rst busy", m.busy, 1);
    checkOutput("pre-rst mem_req", m.mem_req, 1);
    reset = 1; m.pc_in = 1; m.zlo_out = 1; m.mem_ack = 1; m.mem_rdata = 32'hFFFF0000;
    tick(); reset = 0; clear_m();
    checkOutput("rst2 busy", m.busy, 0);
    checkOutput("rst2 mem_req", m.mem_req, 0);
    checkOutput("rst2 err", m.err_sticky, 0);
    checkOutput("rst2 mar", m.mar, 0);
    checkOutput("rst2 ir", m.ir, 0);
    m.pc_out = 1;  #1 checkOutput("rst2 pc", m.bus, 0);  clear_m();
    m.mdr_out = 1; #1 checkOutput("rst2 mdr", m.bus, 0); clear_m();
    m.zlo_out = 1; #1 checkOutput("rst2 zlo", m.bus, 0); clear_m();
    m.zhi_out = 1; #1 checkOutput("rst2 zhi", m.bus, 0); clear_m();
    for (int r = 0; r < 16; r++) begin
      m.reg_out_en = 1; m.reg_out_sel = 4'(r);
      #1 checkOutput($sformatf("rst2 gpr%0d", r), m.bus, 0);
      clear_m();
    end
    m.mdr_out = 1; m.y_in = 1; tick(); clear_m();
    m.mem_ack = 1; m.mem_rdata = 32'h55AA55AA;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (m.done || m.busy) done_seen++;
      tick(); clear_m();
    end
    checkOutput("aborted mul silent", done_seen, 0);
    m.mdr_out = 1; #1 checkOutput("ack after rst ignored", m.bus, 0); clear_m();

    // WIDTH=8, NREGS=4 instance
    reset_s = 0;
    checkOutput("w8 rst busy", s.busy, 0);
    mem_load_s(8'h81);
    s.mdr_out = 1; s.y_in = 1; tick(); clear_s();
    mem_load_s(8'h01);
    s.mdr_out = 1; s.alu_op = 4'd10; s.z_in = 1; s.reg_in_en = 1; s.reg_in_sel = 2'd3; tick(); clear_s();
    s.zlo_out = 1; #1 checkOutput("w8 rol", s.bus, 8'h03); clear_s();
    s.reg_out_en = 1; s.reg_out_sel = 2'd3; #1 checkOutput("w8 gpr3", s.bus, 8'h01); clear_s();
    mem_load_s(8'hFF);
    s.mdr_out = 1; s.y_in = 1; tick(); clear_s();
    mem_load_s(8'hFF);
    s.mdr_out = 1; s.alu_op = 4'd0; s.z_in = 1; tick(); clear_s();
    s.zlo_out = 1; #1 checkOutput("w8 add", s.bus, 8'hFE); clear_s();
    s.mdr_out = 1; s.alu_start = 1; tick(); clear_s();
    busy_cycles = 0;
    for (int i = 0; i < 50 && s.busy; i++) begin busy_cycles++; tick(); end
    checkOutput("w8 busy cycles", busy_cycles, 8);
    checkOutput("w8 done", s.done, 1);
    s.zhi_out = 1; #1 checkOutput("w8 mul zhi", s.bus, 8'hFE); clear_s();
    s.zlo_out = 1; #1 checkOutput("w8 mul zlo", s.bus, 8'h01); clear_s();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/datapath_gen2.md
DATAPATH_GEN2 -- requirements
Module: datapath_gen2

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, bus and register width (even, >= 8).
- NREGS, 16, general-purpose register count (power of two, >= 2).
- RSEL_W, $clog2(NREGS), register index width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- reg_in_en / reg_out_en, in, 1, load selected GPR from bus / drive selected GPR onto bus.
- reg_in_sel / reg_out_sel, in, RSEL_W, GPR index for load / drive.
- pc_out, mdr_out, zlo_out, zhi_out, in, 1 each, bus source enables.
- pc_in, ir_in, y_in, mar_in, mdr_in, z_in, in, 1 each, bus sink load enables.
- inc_pc, in, 1, ALU computes bus+4 regardless of alu_op.
- alu_op, in, 4, ALU operation code.
- alu_start, in, 1, launch multi-cycle MUL.
- mem_read, in, 1, request memory read into MDR.
- mem_ack, in, 1, memory data valid.
- mem_rdata, in, WIDTH, memory read data.
- mem_req, out, 1, outstanding read request.
- mar, out, WIDTH, memory address register.
- ir, out, WIDTH, instruction register.
- bus, out, WIDTH, current bus value.
- busy, out, 1, MUL in progress.
- done, out, 1, one-cycle MUL completion pulse.
- bus_conflict, out, 1, more than one source enabled this cycle (combinational).
- err_sticky, out, 1, latched bus_conflict.

Function
REQ-004 The bus SHALL be combinational: exactly one source enabled drives its value; zero or more than one enabled SHALL drive all-zero.
REQ-005 Sources SHALL be: GPR[reg_out_sel], PC, MDR, Z[WIDTH-1:0] (zlo_out) and Z[2*WIDTH-1:WIDTH] (zhi_out).
REQ-006 Each sink SHALL load the bus on the rising clk edge when its enable is high; GPR[reg_in_sel] SHALL load when reg_in_en is high.
REQ-007 err_sticky SHALL set on any cycle with bus_conflict high and clear only on reset.
REQ-008 Single-cycle ALU ops with A=Y, B=bus, sh=B[$clog2(WIDTH)-1:0]:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT B, 6 NEG B (two's complement).
- 7 SHL A by sh, 8 SHR logical, 9 SAR arithmetic, 10 ROL, 11 ROR.
- 12-15 reserved: result zero.
REQ-009 With z_in high and busy low, Z SHALL load {WIDTH zeros, result}; ADD/SUB carry/borrow SHALL be discarded; inc_pc high SHALL force result = B+4 (mod 2^WIDTH).
REQ-010 MUL (unsigned Y x bus, 2*WIDTH-bit product) SHALL be launched by alu_start high while busy low; alu_op SHALL be ignored for MUL.
REQ-011 MUL operands SHALL be captured on the start edge, and busy SHALL be high for exactly WIDTH cycles following that edge.
REQ-012 On the edge ending the WIDTH-th busy cycle, Z SHALL load the full product, and done SHALL be high for the following single cycle.
REQ-013 While busy is high, z_in and alu_start SHALL be ignored; all other sinks and sources SHALL operate normally.
REQ-014 Memory FSM SHALL have states IDLE and WAIT:
- IDLE + mem_read -> WAIT; mem_req is high in WAIT.
- WAIT + mem_ack -> MDR loads mem_rdata, return to IDLE (mem_req low next cycle).
- mem_ack in IDLE SHALL be ignored.
REQ-015 In WAIT, mdr_in and further mem_read SHALL be ignored; in IDLE, mem_read and mdr_in together SHALL load MDR from the bus and enter WAIT.
REQ-016 mar SHALL reflect the MAR register directly, and ir SHALL reflect IR directly.

Reset
REQ-017 On a clk edge with reset high, the following SHALL clear to zero: all GPRs, PC, IR, Y, Z, MAR, MDR, busy, done, mem_req and err_sticky; the memory FSM SHALL return to IDLE.
REQ-018 Reset SHALL take priority over every load enable, including mid-MUL and in WAIT; an aborted MUL SHALL NOT assert done.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- ADD: Y<=5, bus=GPR3=7, z_in; zlo_out -> bus=12, Z[hi]=0; repeat with SUB 5-7 -> zlo=0xFFFFFFFE.
- MUL: Y=0xFFFFFFFF, bus=2, alu_start -> busy 32 cycles, done one cycle, Z=0x1_FFFFFFFE; alu_start mid-run ignored.
- Conflict: pc_out and mdr_out together -> bus=0, bus_conflict=1, err_sticky stays 1 until reset.
- Memory: mem_read, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_req high 3 cycles, MDR=0xDEADBEEF; early mem_ack in IDLE ignored.
- Shifts: Y=0x80000001, bus=1: SAR -> 0xC0000000, ROR -> 0xC0000000, ROL -> 0x00000003; inc_pc with bus=0xFFFFFFFC -> 0.
- Reset mid-MUL and in WAIT -> all registers zero, busy=0, mem_req=0, done never pulses; parameter sweep WIDTH=8, NREGS=4.
